// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, counter debouncer and press/release/long-press event FSM.
// Define BTN_CONDITIONER_REPEAT_EN to enable the auto-repeat pulse while the button is held in LONG.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int REPEAT_CYCLES   = 2400000,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic hwclk,
  input  logic reset_btn,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_repeat
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 2);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HELD = 2'd1;
  localparam logic [1:0] LONG = 2'd2;

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("btn_conditioner: illegal parameter combination");
  end

  logic            sync1;
  logic            sync2;
  logic            s;
  logic [DW-1:0]   deb_cnt;
  logic            accept;
  logic            rise;
  logic            fall;
  logic [1:0]      state;
  logic [HW-1:0]   hold_cnt;

  always_ff @(posedge hwclk or posedge reset_btn) begin
    if (reset_btn) begin
      sync1 <= BTN_ACTIVE_LOW;
      sync2 <= BTN_ACTIVE_LOW;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ BTN_ACTIVE_LOW;

  // The level flips on the edge where the count of differing cycles completes.
  assign accept = (s != btn_level) && (deb_cnt == DEB_LAST);
  assign rise   = accept && !btn_level;
  assign fall   = accept && btn_level;

  always_ff @(posedge hwclk or posedge reset_btn) begin
    if (reset_btn) begin
      deb_cnt   <= '0;
      btn_level <= 1'b0;
    end else if (s == btn_level) begin
      deb_cnt <= '0;
    end else if (accept) begin
      deb_cnt   <= '0;
      btn_level <= ~btn_level;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge hwclk or posedge reset_btn) begin
    if (reset_btn) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state     <= HELD;
            hold_cnt  <= '0;
            btn_press <= 1'b1;
          end
        end
        HELD: begin
          // A release on the same edge as the long-press threshold wins.
          if (fall) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            btn_release <= 1'b1;
          end else if (hold_cnt == HOLD_FIRE) begin
            state    <= LONG;
            hold_cnt <= hold_cnt + 1'b1;
            btn_long <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG: begin
          if (fall) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            btn_release <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

`ifdef BTN_CONDITIONER_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt;

  always_ff @(posedge hwclk or posedge reset_btn) begin
    if (reset_btn) begin
      rep_cnt    <= '0;
      btn_repeat <= 1'b0;
    end else begin
      btn_repeat <= 1'b0;
      if (state == LONG && !fall) begin
        if (rep_cnt == REP_LAST) begin
          rep_cnt    <= '0;
          btn_repeat <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end else begin
        rep_cnt <= '0;
      end
    end
  end
`else
  assign btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: reset, clean press, bounce, long hold, release race,
// reset mid-hold and the active-low pin variant.
module tb_btn_conditioner;
  localparam int DEB   = 8;
  localparam int LONGC = 40;
  localparam int REP   = 10;

  logic hwclk     = 1'b0;
  logic reset_btn = 1'b1;
  logic btn_in    = 1'b0;
  logic btn_in_al = 1'b1;

  logic btn_level, btn_press, btn_release, btn_long, btn_repeat;
  logic al_level, al_press, al_release, al_long, al_repeat;

  int checks = 0;
  int passes = 0;

  always #5 hwclk = ~hwclk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONGC), .REPEAT_CYCLES(REP), .BTN_ACTIVE_LOW(1'b0)
  ) u_dut (
    .hwclk(hwclk), .reset_btn(reset_btn), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .btn_repeat(btn_repeat)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONGC), .REPEAT_CYCLES(REP), .BTN_ACTIVE_LOW(1'b1)
  ) u_dut_al (
    .hwclk(hwclk), .reset_btn(reset_btn), .btn_in(btn_in_al),
    .btn_level(al_level), .btn_press(al_press), .btn_release(al_release),
    .btn_long(al_long), .btn_repeat(al_repeat)
  );

  task automatic tick;
    @(posedge hwclk);
    #1;
  endtask

  // Expected auto-repeat at offset 'off' cycles after btn_level rose, while still held.
  function automatic bit rep_expected(int off);
    bit en;
`ifdef BTN_CONDITIONER_REPEAT_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && (off >= LONGC - 1 + REP) && (((off - (LONGC - 1)) % REP) == 0);
  endfunction

  task automatic test_reset;
    logic [4:0] obs;
    #1;
    for (int i = 0; i < 5; i++) begin
      obs = {btn_level, btn_press, btn_release, btn_long, btn_repeat};
      checks++;
      if (obs !== 5'b0) $display("FAIL reset_hold cyc=%0d got %b want 00000", i, obs);
      else passes++;
      obs = {al_level, al_press, al_release, al_long, al_repeat};
      checks++;
      if (obs !== 5'b0) $display("FAIL reset_hold_al cyc=%0d got %b want 00000", i, obs);
      else passes++;
      tick();
    end
    reset_btn = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      obs = {btn_level, btn_press, btn_release, btn_long, btn_repeat};
      checks++;
      if (obs !== 5'b0) $display("FAIL reset_idle cyc=%0d got %b want 00000", i, obs);
      else passes++;
      obs = {al_level, al_press, al_release, al_long, al_repeat};
      checks++;
      if (obs !== 5'b0) $display("FAIL reset_idle_al cyc=%0d got %b want 00000", i, obs);
      else passes++;
    end
  endtask

  task automatic test_clean_press;
    btn_in = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      checks++;
      if (btn_press !== (i == DEB + 2)) $display("FAIL clean_press i=%0d got %b want %b", i, btn_press, (i == DEB + 2));
      else passes++;
      checks++;
      if (btn_level !== (i >= DEB + 2)) $display("FAIL clean_level_rise i=%0d got %b want %b", i, btn_level, (i >= DEB + 2));
      else passes++;
      checks++;
      if (btn_long !== (i == DEB + 2 + LONGC - 1)) $display("FAIL clean_long i=%0d got %b want %b", i, btn_long, (i == DEB + 2 + LONGC - 1));
      else passes++;
      checks++;
      if (btn_repeat !== rep_expected(i - (DEB + 2))) $display("FAIL clean_repeat i=%0d got %b want %b", i, btn_repeat, rep_expected(i - (DEB + 2)));
      else passes++;
      checks++;
      if (btn_release !== 1'b0) $display("FAIL clean_no_release i=%0d got %b want 0", i, btn_release);
      else passes++;
    end
    btn_in = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      checks++;
      if (btn_release !== (j == DEB + 2)) $display("FAIL clean_release j=%0d got %b want %b", j, btn_release, (j == DEB + 2));
      else passes++;
      checks++;
      if (btn_level !== (j < DEB + 2)) $display("FAIL clean_level_fall j=%0d got %b want %b", j, btn_level, (j < DEB + 2));
      else passes++;
      checks++;
      if (btn_repeat !== (j < DEB + 2 && rep_expected(90 + j))) $display("FAIL clean_rel_repeat j=%0d got %b want %b", j, btn_repeat, (j < DEB + 2 && rep_expected(90 + j)));
      else passes++;
      checks++;
      if ({btn_press, btn_long} !== 2'b00) $display("FAIL clean_rel_quiet j=%0d got %b want 00", j, {btn_press, btn_long});
      else passes++;
    end
  endtask

  task automatic test_bounce;
    int widths[4] = '{3, 2, 5, 4};
    int presses = 0;
    for (int p = 0; p < 4; p++) begin
      btn_in = (p % 2 == 0);
      for (int k = 0; k < widths[p]; k++) begin
        tick();
        if (btn_press) presses++;
        checks++;
        if (btn_level !== 1'b0) $display("FAIL bounce_level p=%0d k=%0d got %b want 0", p, k, btn_level);
        else passes++;
      end
    end
    btn_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (btn_press) presses++;
      checks++;
      if (btn_press !== (i == DEB + 2)) $display("FAIL bounce_press i=%0d got %b want %b", i, btn_press, (i == DEB + 2));
      else passes++;
      checks++;
      if (btn_level !== (i >= DEB + 2)) $display("FAIL bounce_level_final i=%0d got %b want %b", i, btn_level, (i >= DEB + 2));
      else passes++;
    end
    checks++;
    if (presses != 1) $display("FAIL bounce_press_count got %0d want 1", presses);
    else passes++;
    btn_in = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      checks++;
      if (btn_release !== (j == DEB + 2)) $display("FAIL bounce_release j=%0d got %b want %b", j, btn_release, (j == DEB + 2));
      else passes++;
    end
  endtask

  task automatic test_long_hold;
    btn_in = 1'b1;
    for (int i = 1; i <= DEB + 2; i++) tick();
    checks++;
    if ({btn_level, btn_press} !== 2'b11) $display("FAIL long_press_start got %b want 11", {btn_level, btn_press});
    else passes++;
    for (int off = 1; off <= 80; off++) begin
      tick();
      checks++;
      if (btn_long !== (off == LONGC - 1)) $display("FAIL long_pulse off=%0d got %b want %b", off, btn_long, (off == LONGC - 1));
      else passes++;
      checks++;
      if (btn_repeat !== rep_expected(off)) $display("FAIL long_repeat off=%0d got %b want %b", off, btn_repeat, rep_expected(off));
      else passes++;
      checks++;
      if ({btn_level, btn_press, btn_release} !== 3'b100) $display("FAIL long_level off=%0d got %b want 100", off, {btn_level, btn_press, btn_release});
      else passes++;
    end
    btn_in = 1'b0;
    for (int j = 1; j <= DEB + 2; j++) begin
      tick();
      checks++;
      if (btn_release !== (j == DEB + 2)) $display("FAIL long_release j=%0d got %b want %b", j, btn_release, (j == DEB + 2));
      else passes++;
      checks++;
      if (btn_repeat !== (j < DEB + 2 && rep_expected(80 + j))) $display("FAIL long_rel_repeat j=%0d got %b want %b", j, btn_repeat, (j < DEB + 2 && rep_expected(80 + j)));
      else passes++;
    end
  endtask

  task automatic test_release_race;
    btn_in = 1'b1;
    for (int i = 1; i <= DEB + 2; i++) tick();
    checks++;
    if (btn_press !== 1'b1) $display("FAIL race_press got %b want 1", btn_press);
    else passes++;
    for (int off = 1; off <= 50; off++) begin
      tick();
      checks++;
      if ({btn_long, btn_repeat} !== 2'b00) $display("FAIL race_no_long off=%0d got %b want 00", off, {btn_long, btn_repeat});
      else passes++;
      checks++;
      if (btn_release !== (off == LONGC - 1)) $display("FAIL race_release off=%0d got %b want %b", off, btn_release, (off == LONGC - 1));
      else passes++;
      checks++;
      if (btn_level !== (off < LONGC - 1)) $display("FAIL race_level off=%0d got %b want %b", off, btn_level, (off < LONGC - 1));
      else passes++;
      if (off == LONGC - 1) begin
        checks++;
        if (u_dut.state !== 2'd0) $display("FAIL race_state got %0d want 0", u_dut.state);
        else passes++;
      end
      if (off == LONGC - 1 - (DEB + 2)) btn_in = 1'b0;
    end
  endtask

  task automatic test_reset_mid_hold;
    logic [4:0] obs;
    btn_in = 1'b1;
    for (int i = 1; i <= DEB + 2 + 20; i++) tick();
    checks++;
    if (btn_level !== 1'b1) $display("FAIL midrst_level_before got %b want 1", btn_level);
    else passes++;
    reset_btn = 1'b1;
    #1;
    obs = {btn_level, btn_press, btn_release, btn_long, btn_repeat};
    checks++;
    if (obs !== 5'b0) $display("FAIL midrst_immediate got %b want 00000", obs);
    else passes++;
    for (int k = 1; k <= 5; k++) begin
      tick();
      obs = {btn_level, btn_press, btn_release, btn_long, btn_repeat};
      checks++;
      if (obs !== 5'b0) $display("FAIL midrst_held k=%0d got %b want 00000", k, obs);
      else passes++;
    end
    reset_btn = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if (btn_press !== (i == DEB + 2)) $display("FAIL midrst_press i=%0d got %b want %b", i, btn_press, (i == DEB + 2));
      else passes++;
      checks++;
      if (btn_release !== 1'b0) $display("FAIL midrst_no_release i=%0d got %b want 0", i, btn_release);
      else passes++;
      checks++;
      if (btn_level !== (i >= DEB + 2)) $display("FAIL midrst_level i=%0d got %b want %b", i, btn_level, (i >= DEB + 2));
      else passes++;
    end
    btn_in = 1'b0;
    for (int j = 1; j <= DEB + 2; j++) begin
      tick();
      checks++;
      if (btn_release !== (j == DEB + 2)) $display("FAIL midrst_release j=%0d got %b want %b", j, btn_release, (j == DEB + 2));
      else passes++;
    end
  endtask

  task automatic test_active_low;
    checks++;
    if (al_level !== 1'b0) $display("FAIL al_idle_level got %b want 0", al_level);
    else passes++;
    btn_in_al = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if (al_press !== (i == DEB + 2)) $display("FAIL al_press i=%0d got %b want %b", i, al_press, (i == DEB + 2));
      else passes++;
      checks++;
      if (al_level !== (i >= DEB + 2)) $display("FAIL al_level i=%0d got %b want %b", i, al_level, (i >= DEB + 2));
      else passes++;
    end
    btn_in_al = 1'b1;
    for (int j = 1; j <= DEB + 2; j++) begin
      tick();
      checks++;
      if (al_release !== (j == DEB + 2)) $display("FAIL al_release j=%0d got %b want %b", j, al_release, (j == DEB + 2));
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_release_race();
    test_reset_mid_hold();
    test_active_low();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
